// File: rtl/y86_pkg.sv
// Shared encodings and types for the Y86-64 execute stage.
package y86_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_MUL = 4'h4;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  typedef enum logic {IDLE, MUL} exe_state_t;

  function automatic logic cond_eval(input logic [3:0] fn, input cc_t c);
    logic lt;
    lt = c.sf ^ c.of;
    case (fn)
      C_ALWAYS: return 1'b1;
      C_LE:     return lt | c.zf;
      C_L:      return lt;
      C_E:      return c.zf;
      C_NE:     return !c.zf;
      C_GE:     return !lt;
      C_G:      return !lt && !c.zf;
      default:  return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/y86_execute_stage_if.sv
// Decode-side and memory-side handshake bundle of the execute stage.
interface y86_execute_stage_if #(parameter int W = 64);
  import y86_pkg::*;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [W-1:0] valA;
  logic [W-1:0] valB;
  logic [W-1:0] valC;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] valE;
  logic         cnd;
  cc_t          cc;
  logic         halted;
  logic         err;

  modport master (output in_valid, icode, ifun, valA, valB, valC, out_ready,
                  input  in_ready, out_valid, valE, cnd, cc, halted, err);
  modport slave  (input  in_valid, icode, ifun, valA, valB, valC, out_ready,
                  output in_ready, out_valid, valE, cnd, cc, halted, err);
endinterface

// File: rtl/y86_seq_mul.sv
// Iterative shift-add multiplier, one bit per cycle; compiled only with Y86_MULQ_EN.
`ifdef Y86_MULQ_EN
module y86_seq_mul #(parameter int W = 64) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);
  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d, acc_next;

  always_comb begin
    acc_next = acc_q + (b_q[0] ? a_q : '0);
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    if (start) begin
      cnt_d = CW'(W);
      a_d   = a;
      b_d   = b;
      acc_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q - CW'(1);
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      acc_d = acc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  // done flags the cycle whose iteration is the last one; product already includes it
  assign busy    = (cnt_q != '0);
  assign done    = (cnt_q == CW'(1));
  assign product = acc_next;
endmodule
`endif

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, cnd evaluation, registered result.
// Optional mulq support is enabled by defining Y86_MULQ_EN.
//   state | meaning
//   IDLE  | ready for a new instruction (subject to halt/err/backpressure)
//   MUL   | iterative mulq in progress, input stalled
module y86_execute_stage import y86_pkg::*; #(
  parameter int W          = 64,
  parameter int STACK_STEP = 8
) (
  input logic              clk,
  input logic              rst_n,
  y86_execute_stage_if.slave bus
);
  localparam logic [W-1:0] STEP = W'(STACK_STEP);

  exe_state_t   state_q, state_d;
  logic         out_valid_q, out_valid_d, cnd_q, cnd_d;
  logic         halted_q, halted_d, err_q, err_d;
  logic [W-1:0] vale_q, vale_d;
  cc_t          cc_q, cc_d, alu_cc;
  logic [W-1:0] alu_val, sum, diff, mul_prod;
  logic         cc_we, cnd_v, bad, mul_op, of_v, accept, mul_done, mul_busy;

  assign bus.in_ready = (state_q == IDLE) && !halted_q && !err_q && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    alu_val = '0;
    cc_we   = 1'b0;
    cnd_v   = 1'b0;
    bad     = 1'b0;
    mul_op  = 1'b0;
    of_v    = 1'b0;
    sum     = bus.valB + bus.valA;
    diff    = bus.valB - bus.valA;
    case (bus.icode)
      I_HALT, I_NOP: ;
      I_RRMOVQ, I_JXX: begin
        if (bus.ifun > C_G) bad = 1'b1;
        else cnd_v = cond_eval(bus.ifun, cc_q);
        if (bus.icode == I_RRMOVQ) alu_val = bus.valA;
      end
      I_IRMOVQ:          alu_val = bus.valC;
      I_RMMOVQ, I_MRMOVQ: alu_val = bus.valB + bus.valC;
      I_OPQ: begin
        cc_we = 1'b1;
        case (bus.ifun)
          ALU_ADD: begin
            alu_val = sum;
            of_v    = (bus.valA[W-1] == bus.valB[W-1]) && (sum[W-1] != bus.valB[W-1]);
          end
          ALU_SUB: begin
            alu_val = diff;
            of_v    = (bus.valA[W-1] != bus.valB[W-1]) && (diff[W-1] != bus.valB[W-1]);
          end
          ALU_AND: alu_val = bus.valB & bus.valA;
          ALU_XOR: alu_val = bus.valB ^ bus.valA;
          ALU_MUL: begin
`ifdef Y86_MULQ_EN
            mul_op = 1'b1;
`else
            bad = 1'b1;
`endif
          end
          default: bad = 1'b1;
        endcase
      end
      I_CALL, I_PUSHQ: alu_val = bus.valB - STEP;
      I_RET, I_POPQ:   alu_val = bus.valB + STEP;
      default:         bad = 1'b1;
    endcase
    if (bad) begin
      alu_val = '0;
      cc_we   = 1'b0;
      cnd_v   = 1'b0;
    end
    alu_cc.zf = (alu_val == '0);
    alu_cc.sf = alu_val[W-1];
    alu_cc.of = of_v;
  end

`ifdef Y86_MULQ_EN
  y86_seq_mul #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && mul_op),
    .a       (bus.valB),
    .b       (bus.valA),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    vale_d      = vale_q;
    cnd_d       = cnd_q;
    cc_d        = cc_q;
    halted_d    = halted_q;
    err_d       = err_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mul_op) begin
            state_d = MUL;
          end else begin
            out_valid_d = 1'b1;
            vale_d      = alu_val;
            cnd_d       = cnd_v;
            if (cc_we) cc_d = alu_cc;
            if (bus.icode == I_HALT) halted_d = 1'b1;
            if (bad) err_d = 1'b1;
          end
        end
      end
      MUL: begin
        // the output register drained when mulq was accepted, so loading here never overwrites
        if (mul_done) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          vale_d      = mul_prod;
          cnd_d       = 1'b0;
          cc_d.zf     = (mul_prod == '0);
          cc_d.sf     = mul_prod[W-1];
          cc_d.of     = 1'b0;
        end else if (!mul_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      vale_q      <= '0;
      cnd_q       <= 1'b0;
      cc_q        <= CC_RESET;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      vale_q      <= vale_d;
      cnd_q       <= cnd_d;
      cc_q        <= cc_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.valE      = vale_q;
  assign bus.cnd       = cnd_q;
  assign bus.cc        = cc_q;
  assign bus.halted    = halted_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_y86_execute_stage.sv
// Scoreboard bench for y86_execute_stage; mulq cases follow Y86_MULQ_EN.
module tb_y86_execute_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;
  logic [2:0] mcc = 3'b100;

  typedef struct {
    string       tag;
    logic [63:0] vale;
    logic        cnd;
    logic [2:0]  cc;
  } exp_t;
  exp_t sb[$];

  y86_execute_stage_if #(.W(64)) bus();

  y86_execute_stage #(.W(64), .STACK_STEP(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] fn);
    bit zf, sf, of;
    zf = mcc[2]; sf = mcc[1]; of = mcc[0];
    case (fn)
      4'd0: return 1'b1;
      4'd1: return (sf != of) || zf;
      4'd2: return sf != of;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return sf == of;
      4'd6: return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // reference model: expected result for one instruction, advancing model CC
  task automatic model(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    exp_t e;
    logic [63:0] r;
    bit bad, setcc, cd, of;
    r = 64'd0; bad = 0; setcc = 0; cd = 0; of = 0;
    case (ic)
      4'h0, 4'h1: ;
      4'h2, 4'h7: if (fn > 4'd6) bad = 1; else begin cd = cond_ok(fn); if (ic == 4'h2) r = a; end
      4'h3: r = c;
      4'h4, 4'h5: r = b + c;
      4'h6: begin
        setcc = 1;
        case (fn)
          4'd0: begin r = b + a; of = (a[63] == b[63]) && (r[63] != a[63]); end
          4'd1: begin r = b - a; of = (a[63] != b[63]) && (r[63] != b[63]); end
          4'd2: r = b & a;
          4'd3: r = b ^ a;
`ifdef Y86_MULQ_EN
          4'd4: r = b * a;
`endif
          default: bad = 1;
        endcase
      end
      4'h8, 4'hA: r = b - 64'd8;
      4'h9, 4'hB: r = b + 64'd8;
      default: bad = 1;
    endcase
    if (bad) begin r = 64'd0; cd = 0; setcc = 0; end
    if (setcc) mcc = {r == 64'd0, r[63], of};
    e.tag = tag; e.vale = r; e.cnd = cd; e.cc = mcc;
    sb.push_back(e);
  endtask

  task automatic send(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      output int waits);
    bit acc;
    bus.icode = ic; bus.ifun = fn; bus.valA = a; bus.valB = b; bus.valC = c;
    bus.in_valid = 1'b1;
    waits = 0; acc = 0;
    while (!acc) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model(tag, ic, fn, a, b, c);
        acc = 1;
      end else begin
        waits++;
        if (waits > 200) begin
          check({tag, "_accept_timeout"}, 64'd0, 64'd1);
          break;
        end
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic reset_assert();
    rst_n = 1'b0;
    sb.delete();
    mcc = 3'b100;
  endtask

  task automatic reset_release();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_valE"},      bus.valE, 64'd0);
    check({tag, "_cnd"},       bus.cnd, 1'b0);
    check({tag, "_cc"},        bus.cc, 3'b100);
    check({tag, "_halted"},    bus.halted, 1'b0);
    check({tag, "_err"},       bus.err, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_valE"}, bus.valE, e.vale);
        check({e.tag, "_cnd"},  bus.cnd,  e.cnd);
        check({e.tag, "_cc"},   bus.cc,   e.cc);
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int w, c0, lat;
    logic [3:0] ics [11] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
    bus.in_valid = 1'b0; bus.icode = 4'h1; bus.ifun = 4'h0;
    bus.valA = 64'd0; bus.valB = 64'd0; bus.valC = 64'd0; bus.out_ready = 1'b1;

    #2 reset_assert();
    #1 check_reset_vals("rst0");
    repeat (2) @(posedge clk);
    reset_release();
    check("rst0_in_ready", bus.in_ready, 1'b1);

    send("add_ovf", 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, w);
    check("add_latency", bus.out_valid, 1'b1);

    c0 = cyc;
    send("sub_eq", 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, w);
    send("je",     4'h7, 4'h3, 64'd0, 64'd0, 64'd0, w);
    send("jne",    4'h7, 4'h4, 64'd0, 64'd0, 64'd0, w);
    send("irmov",  4'h3, 4'h0, 64'd0, 64'd0, 64'h1234_5678_9ABC_DEF0, w);
    check("throughput_cycles", 64'(cyc - c0), 64'd4);

    send("push", 4'hA, 4'h0, 64'd0, 64'h100, 64'd0, w);
    bus.out_ready = 1'b0;
    bus.icode = 4'h5; bus.ifun = 4'h0; bus.valB = 64'h200; bus.valC = 64'h18; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valE", bus.valE, 64'hF8);
      check("hold_in_ready", bus.in_ready, 1'b0);
      check("hold_out_valid", bus.out_valid, 1'b1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send("mrmov", 4'h5, 4'h0, 64'd0, 64'h200, 64'h18, w);
    check("release_wait", 64'(w), 64'd0);

    send("halt", 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, w);
    check("halt_halted", bus.halted, 1'b1);
    check("halt_in_ready", bus.in_ready, 1'b0);
    bus.icode = 4'h1; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halt_blocked", bus.in_ready, 1'b0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("halt_drained", 64'(sb.size()), 64'd0);
    @(negedge clk); #1 reset_assert();
    #1 check_reset_vals("rst_halt");
    reset_release();

    send("sub_neg", 4'h6, 4'h1, 64'd5, 64'd3, 64'd0, w);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send("bad_icode", 4'hC, 4'h0, 64'd1, 64'd2, 64'd3, w);
    check("bad_icode_err", bus.err, 1'b1);
    check("bad_icode_valE", bus.valE, 64'd0);
    check("bad_icode_cc", bus.cc, 3'b010);
    check("bad_icode_in_ready", bus.in_ready, 1'b0);
    @(negedge clk); #2 reset_assert();
    #1 check_reset_vals("rst_async");
    bus.out_ready = 1'b1;
    reset_release();

    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [3:0] ic, fn;
      ic = ics[$urandom_range(0, 10)];
      fn = 4'h0;
      if (ic == 4'h6) fn = 4'($urandom_range(0, 3));
      else if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
      send($sformatf("rnd%0d", i), ic, fn, rnd_op(), rnd_op(), rnd_op(), w);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1 bus.out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rnd_drained", 64'(sb.size()), 64'd0);

    send("bad_opq", 4'h6, 4'h5, 64'd1, 64'd1, 64'd0, w);
    check("bad_opq_err", bus.err, 1'b1);
    reset_assert(); reset_release();
    send("bad_cond", 4'h7, 4'h7, 64'd0, 64'd0, 64'd0, w);
    check("bad_cond_err", bus.err, 1'b1);
    reset_assert(); reset_release();

`ifdef Y86_MULQ_EN
    send("mulq", 4'h6, 4'h4, 64'h3, 64'h1_0000_0000, 64'd0, w);
    lat = 1;
    check("mulq_in_ready", bus.in_ready, 1'b0);
    while (!bus.out_valid && lat < 200) begin @(posedge clk); #1 lat++; end
    check("mulq_latency", 64'(lat), 64'd65);
    @(posedge clk); #1;
    send("mulq_abort", 4'h6, 4'h4, 64'h3, 64'h5, 64'd0, w);
    repeat (29) @(posedge clk);
    #1 check("mulq_busy_in_ready", bus.in_ready, 1'b0);
    reset_assert();
    #1 check("mulq_abort_out_valid", bus.out_valid, 1'b0);
    reset_release();
    repeat (80) @(posedge clk);
    #1 check("mulq_abort_no_out", bus.out_valid, 1'b0);
    check("mulq_abort_in_ready", bus.in_ready, 1'b1);
`else
    send("mulq_off", 4'h6, 4'h4, 64'h3, 64'h1_0000_0000, 64'd0, w);
    check("mulq_off_err", bus.err, 1'b1);
    check("mulq_off_latency", bus.out_valid, 1'b1);
    lat = 0;
`endif
    repeat (3) @(posedge clk); #1;
    check("final_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
